// File: rtl/arb_pkg.sv
// Shared arbitration constants for the 4-way round-robin arbiter:
// requester count, select width, FSM state codes and a one-hot helper.
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    // FSM state codes, kept as plain constants so older blocks can reuse them.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // One-hot vector with only bit idx set.
    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/multiplexer4x1.sv
// Gate-level 4:1 multiplexer: y = w[sel], built from primitive gates only.
module multiplexer4x1 (
    input  logic [3:0] w,
    input  logic [1:0] sel,
    output logic       y
);

    logic       s0_n;
    logic       s1_n;
    logic [3:0] term;

    not u_inv0 (s0_n, sel[0]);
    not u_inv1 (s1_n, sel[1]);

    and u_and0 (term[0], w[0], s1_n,   s0_n);
    and u_and1 (term[1], w[1], s1_n,   sel[0]);
    and u_and2 (term[2], w[2], sel[1], s0_n);
    and u_and3 (term[3], w[3], sel[1], sel[0]);

    or  u_or   (y, term[0], term[1], term[2], term[3]);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter in front of a 4:1 data mux.
// One grant at a time; every grant ends in IDLE for a bubble cycle so the
// served requester can drop its request before the next arbitration.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  w,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             y,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  done,
    output logic [CNT_W-1:0] xfer_count
);

    logic [0:0]       state_reg,  state_next;
    logic [SEL_W-1:0] ptr_reg,    ptr_next;
    logic [SEL_W-1:0] sel_reg,    sel_next;
    logic [NREQ-1:0]  grant_reg,  grant_next;
    logic [CNT_W-1:0] count_reg,  count_next;

    // Requests viewed in scan order: slot k holds requester (ptr + k) mod 4.
    logic [SEL_W-1:0] rot_idx [NREQ];
    logic [NREQ-1:0]  rot_req;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_valid;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot_idx[gi] = ptr_reg + SEL_W'(gi);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    // Round-robin pick: the lowest scan slot with a request wins.
    always_comb begin
        pick_valid = |req;
        pick_idx   = ptr_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_idx = rot_idx[k];
            end
        end
    end

    // Next-state logic for the IDLE/GRANT FSM and its datapath registers.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        grant_next = grant_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_GRANT;
                    sel_next   = pick_idx;
                    grant_next = onehot(pick_idx);
                end
            end
            ST_GRANT: begin
                // A ready downstream wins even if the request drops this cycle.
                if (out_ready) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = sel_reg + SEL_W'(1);
                    count_next = count_reg + CNT_W'(1);
                end else if (!req[sel_reg]) begin
                    // Requester gave up before the transfer: abandon silently.
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            sel_reg   <= '0;
            grant_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            grant_reg <= grant_next;
            count_reg <= count_next;
        end
    end

    // A reset cycle never reports a completed transfer.
    assign done       = (state_reg == ST_GRANT && !rst) ? (grant_reg & {NREQ{out_ready}}) : '0;
    assign out_valid  = (state_reg == ST_GRANT);
    assign sel        = sel_reg;
    assign grant      = grant_reg;
    assign xfer_count = count_reg;

    multiplexer4x1 u_mux (
        .w   (w),
        .sel (sel_reg),
        .y   (y)
    );

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the transfer counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port req, input, 4, per-requester request level; req[i] is held until done[i] is seen.
REQ-005 SHALL have port w, input, 4, per-requester data bit; w[i] is held stable while req[i] is high.
REQ-006 SHALL have port out_ready, input, 1, downstream accepts y this cycle.
REQ-007 SHALL have port out_valid, output, 1, y carries granted requester's bit.
REQ-008 SHALL have port y, output, 1, selected data bit, w[sel].
REQ-009 SHALL have port sel, output, 2, registered index of the granted requester.
REQ-010 SHALL have port grant, output, 4, one-hot grant, all-zero when idle.
REQ-011 SHALL have port done, output, 4, one-cycle pulse; done[i] = grant[i] & out_ready while in GRANT.
REQ-012 SHALL have port xfer_count, output, CNT_W, count of completed transfers.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-014 SHALL, in IDLE with req != 0, select the first asserted req[i] scanning ptr, ptr+1, ... mod 4, and enter GRANT next cycle with sel = i and grant = one-hot(i).
REQ-015 SHALL, in IDLE with req == 0, remain in IDLE; sel and ptr unchanged.
REQ-016 SHALL drive out_valid = 1 exactly while in GRANT; y is combinational w[sel], with 0 latency from w.
REQ-017 SHALL complete a transfer when out_valid & out_ready; next cycle: IDLE, grant = 0, ptr = (sel + 1) mod 4, and xfer_count incremented.
REQ-018 SHALL always return to IDLE for one bubble cycle after each transfer, so that the served requester can drop req before re-arbitration.
REQ-019 SHALL hold grant, sel and out_valid stable in GRANT while out_ready = 0, with no timeout.
REQ-020 SHALL abandon the grant if req[sel] falls in GRANT without out_ready: IDLE next cycle, no done, ptr and xfer_count unchanged.
REQ-021 SHALL let out_ready win when out_ready = 1 coincides with req[sel] falling in the same cycle: counted as a transfer, with done asserted.
REQ-022 SHALL let xfer_count wrap from 2^CNT_W-1 to 0 without a flag.
REQ-023 SHALL guarantee that any continuously asserted req[i] is granted within 4 grants.
REQ-024 SHALL ignore out_ready and w in IDLE.

Reset
REQ-025 SHALL, when rst = 1 at a clock edge, force IDLE, ptr = 0, sel = 0, grant = 0, out_valid = 0, done = 0 and xfer_count = 0, regardless of state.
REQ-026 SHALL, on reset mid-GRANT, drop out_valid and grant the next cycle without counting or pulsing done.
REQ-027 SHALL begin arbitration on the first edge after rst falls, starting from index 0.

Structure
REQ-028 SHALL take the state encoding (IDLE/GRANT), NREQ = 4 and SEL_W = 2 from shared package arb_pkg.
REQ-029 SHALL produce y through one instance of the existing gate-level 4:1 mux module multiplexer4x1 (.w(w), .sel(sel), .y(y)); the arbitration logic stays in this module.
REQ-030 SHALL implement the round-robin pick as combinational logic feeding registered sel/grant; no other sub-modules.

Verification
REQ-031 SHALL be checked with: rst 2 cycles, req = 0 -> out_valid = 0, grant = 0, xfer_count = 0, state IDLE throughout.
REQ-032 SHALL be checked with: req = 4'b0100, w = 4'b0100, out_ready = 1 -> next cycle grant = 0100, sel = 2, y = 1, done = 0100; then IDLE, xfer_count = 1, ptr = 3.
REQ-033 SHALL be checked with: req = 4'b1111 held (each requester re-raises after its done), out_ready = 1 -> grant order 0, 1, 2, 3, 0, with a bubble between grants, and xfer_count = 5.
REQ-034 SHALL be checked with: grant on index 1, out_ready = 0 for 5 cycles -> grant, sel and out_valid stable, with no done; then out_ready = 1 -> a single done[1] pulse.
REQ-035 SHALL be checked with: grant on index 3, req[3] dropped with out_ready = 0 -> IDLE next cycle, no done, xfer_count unchanged, ptr unchanged.
REQ-036 SHALL be checked with: rst asserted mid-GRANT, and separately xfer_count = 255 (CNT_W = 8) plus one transfer -> outputs at reset values next cycle; counter reads 0.
